// File: rtl/crc_pkg.sv
// Shared types and elaboration helpers for the streaming CRC engine (crc_stream).
// Holds the FSM state encoding, the STEPS computation and the parameter legality check.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  function automatic int crc_steps(input int data_w, input int bpc);
    return data_w / bpc;
  endfunction

  function automatic bit crc_params_ok(input int crc_w, input int data_w, input int bpc);
    return (crc_w >= 2) && (crc_w <= 64) &&
           (bpc >= 1) && (bpc <= data_w) &&
           ((data_w % bpc) == 0);
  endfunction

endpackage

// File: rtl/crc_fold.sv
// Combinational fold of BITS_PER_CYCLE message bits into a CRC register.
// bits_i[BITS_PER_CYCLE-1] is applied first; the polynomial omits its implicit leading 1.
module crc_fold
  import crc_pkg::*;
#(
  parameter int CRC_W          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [CRC_W-1:0]          crc_i,
  input  logic [CRC_W-1:0]          poly_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic [CRC_W-1:0]          crc_o
);

  logic [CRC_W-1:0] acc;

  always_comb begin
    acc = crc_i;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      if (acc[CRC_W-1] ^ bits_i[i]) begin
        acc = (acc << 1) ^ poly_i;
      end else begin
        acc = acc << 1;
      end
    end
    crc_o = acc;
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: words in over valid/ready, final CRC out over valid/ready.
// Define CRC_REFLECT_EN for LSB-first input words and a bit-reversed final register.
module crc_stream
  import crc_pkg::*;
#(
  parameter int CRC_W          = 8,
  parameter int DATA_W         = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CRC_W-1:0]  poly,
  input  logic [CRC_W-1:0]  init,
  input  logic [CRC_W-1:0]  xor_out,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              busy
);

  localparam int STEPS = crc_steps(DATA_W, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (!crc_params_ok(CRC_W, DATA_W, BITS_PER_CYCLE)) begin : g_param_check
    $error("crc_stream: illegal CRC_W/DATA_W/BITS_PER_CYCLE combination");
  end

  crc_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                last_q, last_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [CRC_W-1:0]    out_crc_q, out_crc_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CRC_W-1:0]    poly_q, poly_d;
  logic [CRC_W-1:0]    xor_q, xor_d;

  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [DATA_W-1:0]         shift_next;
  logic [CRC_W-1:0]          fold_crc;

  function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] c,
                                                input logic [CRC_W-1:0] x);
`ifdef CRC_REFLECT_EN
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r ^ x;
`else
    return c ^ x;
`endif
  endfunction

`ifdef CRC_REFLECT_EN
  // Reflected input: the word's LSB is the first bit fed to the fold.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) chunk[BITS_PER_CYCLE-1-i] = shift_q[i];
  end
  assign shift_next = shift_q >> BITS_PER_CYCLE;
`else
  assign chunk      = shift_q[DATA_W-1 -: BITS_PER_CYCLE];
  assign shift_next = shift_q << BITS_PER_CYCLE;
`endif

  crc_fold #(
    .CRC_W          (CRC_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_fold (
    .crc_i  (crc_q),
    .poly_i (poly_q),
    .bits_i (chunk),
    .crc_o  (fold_crc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    last_d    = last_q;
    crc_d     = crc_q;
    out_crc_d = out_crc_q;
    shift_d   = shift_q;
    poly_d    = poly_q;
    xor_d     = xor_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          last_d  = in_last;
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
          // Message-wide settings are captured only on the first word.
          if (!busy_q) begin
            crc_d  = init;
            poly_d = poly;
            xor_d  = xor_out;
          end
        end
      end
      SHIFT: begin
        crc_d   = fold_crc;
        shift_d = shift_next;
        if (cnt_q == LAST_STEP) begin
          if (last_q) begin
            out_crc_d = finalize(fold_crc, xor_q);
            state_d   = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      crc_q     <= '0;
      out_crc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      crc_q     <= crc_d;
      out_crc_q <= out_crc_d;
    end
  end

  // Pure datapath holding registers; their contents are only used after a fresh load.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    poly_q  <= poly_d;
    xor_q   <= xor_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_crc   = out_crc_q;
  assign busy      = busy_q;

endmodule
